// File: rtl/int_mult_pipe.sv
// Pipelined unsigned multiplier: limb products (S1), carry-save reduction (S2),
// final add with FULL/SQUARE/HIGH/LOW selection (S3). One global advance enable.
module int_mult_pipe #(
    parameter int DATA_W  = 256,
    parameter int CHUNK_W = 16,
    parameter int TAG_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [1:0]          in_mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_c,
    output logic [TAG_W-1:0]    out_tag,
    output logic                busy
);
    localparam int NCH = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PW  = NCH * CHUNK_W;
    localparam int NP  = NCH * NCH;
    localparam int PRW = 2 * CHUNK_W;
    localparam int RW  = 2 * DATA_W;

    localparam logic [1:0] MODE_SQUARE = 2'b01;
    localparam logic [1:0] MODE_HIGH   = 2'b10;
    localparam logic [1:0] MODE_LOW    = 2'b11;

    logic              adv;
    logic [PW-1:0]     a_pad;
    logic [PW-1:0]     b_pad;
    logic [PRW-1:0]    prod_next [NP];
    logic [PRW-1:0]    prod_reg  [NP];
    logic              s1_valid_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic [1:0]        s1_mode_reg;

    logic [RW-1:0]     sum_next;
    logic [RW-1:0]     carry_next;
    logic [RW-1:0]     term;
    logic [RW-1:0]     s_tmp;
    logic [RW-1:0]     c_tmp;
    logic [RW-1:0]     s2_sum_reg;
    logic [RW-1:0]     s2_carry_reg;
    logic              s2_valid_reg;
    logic [TAG_W-1:0]  s2_tag_reg;
    logic [1:0]        s2_mode_reg;

    logic [RW-1:0]     full_sum;
    logic [RW-1:0]     result_next;
    logic              out_valid_reg;
    logic [RW-1:0]     out_c_reg;
    logic [TAG_W-1:0]  out_tag_reg;

    // Every stage moves together; a held result freezes the whole pipe.
    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_reg;
    assign out_c     = out_c_reg;
    assign out_tag   = out_tag_reg;
    assign busy      = s1_valid_reg || s2_valid_reg || out_valid_reg;

    // Zero padding of the top limb keeps the padded product bits at zero.
    assign a_pad = PW'(in_a);
    assign b_pad = (in_mode == MODE_SQUARE) ? a_pad : PW'(in_b);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_row
            for (genvar gj = 0; gj < NCH; gj++) begin : g_col
                assign prod_next[gi*NCH+gj] = PRW'(a_pad[gi*CHUNK_W +: CHUNK_W])
                                            * PRW'(b_pad[gj*CHUNK_W +: CHUNK_W]);
            end
        end
    endgenerate

    // Carry-save accumulation of the shifted limb products; exact modulo 2^RW
    // because the true product never exceeds RW bits.
    always_comb begin
        sum_next   = '0;
        carry_next = '0;
        term       = '0;
        s_tmp      = '0;
        c_tmp      = '0;
        for (int p = 0; p < NP; p++) begin
            term       = RW'(prod_reg[p]) << ((p / NCH + p % NCH) * CHUNK_W);
            s_tmp      = sum_next ^ carry_next ^ term;
            c_tmp      = ((sum_next & carry_next) | (sum_next & term) | (carry_next & term)) << 1;
            sum_next   = s_tmp;
            carry_next = c_tmp;
        end
    end

    always_comb begin
        full_sum    = s2_sum_reg + s2_carry_reg;
        result_next = full_sum;
        case (s2_mode_reg)
            MODE_HIGH: result_next = {{DATA_W{1'b0}}, full_sum[RW-1:DATA_W]};
            MODE_LOW:  result_next = {{DATA_W{1'b0}}, full_sum[DATA_W-1:0]};
            default:   result_next = full_sum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_c_reg     <= '0;
            out_tag_reg   <= '0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            out_c_reg     <= result_next;
            out_tag_reg   <= s2_tag_reg;
        end
    end

    // Datapath registers need no reset: their contents only matter behind a valid.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag_reg   <= in_tag;
            s1_mode_reg  <= in_mode;
            for (int p = 0; p < NP; p++) begin
                prod_reg[p] <= prod_next[p];
            end
            s2_tag_reg   <= s1_tag_reg;
            s2_mode_reg  <= s1_mode_reg;
            s2_sum_reg   <= sum_next;
            s2_carry_reg <= carry_next;
        end
    end
endmodule

// File: tb/tb_int_mult_pipe.sv
// Directed bench for int_mult_pipe: 32-bit, 255-bit and single-limb 12-bit instances.
module tb_int_mult_pipe;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 32-bit instance
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_busy;
    logic [31:0] n_a, n_b;
    logic [1:0]  n_mode;
    logic [7:0]  n_tag, n_out_tag;
    logic [63:0] n_out_c;

    // 255-bit instance
    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [254:0] w_a, w_b;
    logic [1:0]   w_mode;
    logic [7:0]   w_tag, w_out_tag;
    logic [509:0] w_out_c;

    // 12-bit instance (one limb)
    logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_busy;
    logic [11:0] t_a, t_b;
    logic [1:0]  t_mode;
    logic [3:0]  t_tag, t_out_tag;
    logic [23:0] t_out_c;

    int_mult_pipe #(.DATA_W(32), .CHUNK_W(16), .TAG_W(8)) u_narrow (
        .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_a(n_a), .in_b(n_b), .in_mode(n_mode), .in_tag(n_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_c(n_out_c),
        .out_tag(n_out_tag), .busy(n_busy));

    int_mult_pipe #(.DATA_W(255), .CHUNK_W(16), .TAG_W(8)) u_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_a), .in_b(w_b), .in_mode(w_mode), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_c(w_out_c),
        .out_tag(w_out_tag), .busy(w_busy));

    int_mult_pipe #(.DATA_W(12), .CHUNK_W(16), .TAG_W(4)) u_tiny (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_a(t_a), .in_b(t_b), .in_mode(t_mode), .in_tag(t_tag),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_c(t_out_c),
        .out_tag(t_out_tag), .busy(t_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic n_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                        input logic [7:0] tag, input logic [63:0] exp, input string name);
        n_a = a; n_b = b; n_mode = mode; n_tag = tag; n_in_valid = 1'b1;
        tick();
        n_in_valid = 1'b0;
        tick();
        tick();
        check({name, "_valid"}, 512'(n_out_valid), 512'(1));
        check({name, "_c"}, 512'(n_out_c), 512'(exp));
        check({name, "_tag"}, 512'(n_out_tag), 512'(tag));
        $display("narrow %s a=%h b=%h mode=%0d -> c=%h tag=%h", name, a, b, mode, n_out_c, n_out_tag);
    endtask

    task automatic w_op(input logic [254:0] a, input logic [254:0] b, input logic [1:0] mode,
                        input logic [7:0] tag);
        logic [509:0] full;
        logic [509:0] exp;
        full = (mode == 2'b01) ? 510'(a) * 510'(a) : 510'(a) * 510'(b);
        case (mode)
            2'b10:   exp = 510'(full[509:255]);
            2'b11:   exp = 510'(full[254:0]);
            default: exp = full;
        endcase
        w_a = a; w_b = b; w_mode = mode; w_tag = tag; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        tick();
        tick();
        check("wide_valid", 512'(w_out_valid), 512'(1));
        check("wide_c", 512'(w_out_c), 512'(exp));
        check("wide_tag", 512'(w_out_tag), 512'(tag));
        $display("wide mode=%0d tag=%0d -> valid=%0b tag=%0d", mode, tag, w_out_valid, w_out_tag);
    endtask

    task automatic t_op(input logic [11:0] a, input logic [11:0] b, input logic [1:0] mode,
                        input logic [3:0] tag, input logic [23:0] exp);
        t_a = a; t_b = b; t_mode = mode; t_tag = tag; t_in_valid = 1'b1;
        tick();
        t_in_valid = 1'b0;
        tick();
        tick();
        check("tiny_valid", 512'(t_out_valid), 512'(1));
        check("tiny_c", 512'(t_out_c), 512'(exp));
        check("tiny_tag", 512'(t_out_tag), 512'(tag));
        $display("tiny a=%h b=%h mode=%0d -> c=%h", a, b, mode, t_out_c);
    endtask

    initial begin
        logic [255:0] pat_full;
        logic [254:0] pat1, pat2;

        reset = 1'b1;
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_a = '0; n_b = '0; n_mode = '0; n_tag = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_mode = '0; w_tag = '0;
        t_in_valid = 1'b0; t_out_ready = 1'b1; t_a = '0; t_b = '0; t_mode = '0; t_tag = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 512'(n_out_valid), 512'(0));
        check("rst_busy", 512'(n_busy), 512'(0));
        check("rst_in_ready", 512'(n_in_ready), 512'(1));
        check("rst_out_c", 512'(n_out_c), 512'(0));
        check("rst_out_tag", 512'(n_out_tag), 512'(0));
        check("rst_wide_ready", 512'({w_in_ready, w_busy}), 512'(2'b10));
        check("rst_tiny_ready", 512'({t_in_ready, t_busy}), 512'(2'b10));
        $display("reset: out_valid=%0b busy=%0b in_ready=%0b", n_out_valid, n_busy, n_in_ready);

        // Latency: result appears in the third cycle after the accept cycle
        n_a = 32'hFFFF_FFFF; n_b = 32'hFFFF_FFFF; n_mode = 2'b00; n_tag = 8'hA5; n_in_valid = 1'b1;
        tick();
        n_in_valid = 1'b0;
        check("lat_c1_valid", 512'(n_out_valid), 512'(0));
        check("lat_c1_busy", 512'(n_busy), 512'(1));
        tick();
        check("lat_c2_valid", 512'(n_out_valid), 512'(0));
        tick();
        check("lat_c3_valid", 512'(n_out_valid), 512'(1));
        check("lat_c3_c", 512'(n_out_c), 512'(64'hFFFF_FFFE_0000_0001));
        check("lat_c3_tag", 512'(n_out_tag), 512'(8'hA5));
        $display("latency op: c=%h tag=%h", n_out_c, n_out_tag);
        tick();
        check("lat_drain", 512'(n_out_valid), 512'(0));

        // Back-to-back stream of 8 operations
        for (int i = 0; i < 11; i++) begin
            n_in_valid = (i < 8);
            n_a = 32'(i + 1); n_b = 32'd3; n_mode = 2'b00; n_tag = 8'(i);
            tick();
            if (i >= 2 && i <= 9) begin
                check("b2b_valid", 512'(n_out_valid), 512'(1));
                check("b2b_c", 512'(n_out_c), 512'(3 * (i - 1)));
                check("b2b_tag", 512'(n_out_tag), 512'(i - 2));
                $display("b2b result tag=%0d c=%0d", n_out_tag, n_out_c);
            end
        end
        n_in_valid = 1'b0;
        check("b2b_end", 512'(n_out_valid), 512'(0));

        // Mode selection
        n_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 8'h10, 64'h0B00_EA4E_242D_2080, "full");
        n_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b10, 8'h11, 64'h0000_0000_0B00_EA4E, "high");
        n_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 8'h12, 64'h0000_0000_242D_2080, "low");
        n_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 8'h13, 64'h014B_66DC_1DF4_D840, "square");
        n_op(32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 8'h14, 64'h0, "zero");

        // Backpressure with three operations in flight
        tick();
        n_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_a = 32'(10 * (i + 1)); n_b = 32'd7; n_mode = 2'b00; n_tag = 8'(i + 1); n_in_valid = 1'b1;
            tick();
        end
        n_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 512'(n_in_ready), 512'(0));
            check("stall_valid", 512'(n_out_valid), 512'(1));
            check("stall_c", 512'(n_out_c), 512'(70));
            check("stall_tag", 512'(n_out_tag), 512'(1));
            $display("stall cycle %0d: in_ready=%0b c=%0d tag=%0d", i, n_in_ready, n_out_c, n_out_tag);
            tick();
        end
        n_out_ready = 1'b1;
        #1;
        check("release_in_ready", 512'(n_in_ready), 512'(1));
        tick();
        check("release_c2", 512'({n_out_valid, n_out_tag, n_out_c}), 512'({1'b1, 8'd2, 64'd140}));
        tick();
        check("release_c3", 512'({n_out_valid, n_out_tag, n_out_c}), 512'({1'b1, 8'd3, 64'd210}));
        tick();
        check("release_drain", 512'({n_out_valid, n_busy}), 512'(0));
        $display("stall release: drained, busy=%0b", n_busy);

        // Reset with two operations in flight; op offered in the reset cycle is dropped
        for (int i = 0; i < 2; i++) begin
            n_a = 32'd5; n_b = 32'd5; n_mode = 2'b00; n_tag = 8'(8 + i); n_in_valid = 1'b1;
            tick();
        end
        n_tag = 8'hEE;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_in_valid = 1'b0;
        check("midrst_valid", 512'(n_out_valid), 512'(0));
        check("midrst_busy", 512'(n_busy), 512'(0));
        check("midrst_in_ready", 512'(n_in_ready), 512'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_stale", 512'({n_out_valid, n_busy}), 512'(0));
        end
        $display("mid reset: out_valid=%0b busy=%0b", n_out_valid, n_busy);

        // Wide operands with padded top limb
        pat_full = {8{32'hDEAD_BEEF}};
        pat1 = pat_full[254:0];
        pat2 = 255'h1 << 254;
        pat2[31:0] = 32'h8765_4321;
        for (int m = 0; m < 4; m++) begin
            w_op('1, '1, 2'(m), 8'(m));
            w_op(pat1, pat2, 2'(m), 8'(8 + m));
        end

        // Single limb: no partial products to reduce
        t_op(12'hFFF, 12'hFFF, 2'b00, 4'h1, 24'hFF_E001);
        t_op(12'hFFF, 12'hFFF, 2'b10, 4'h2, 24'h00_0FFE);
        t_op(12'hFFF, 12'hFFF, 2'b11, 4'h3, 24'h00_0001);
        t_op(12'hABC, 12'h123, 2'b01, 4'h4, 24'h73_3A10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
